// File: rtl/vector_gather.sv
// vector_gather: issues per-lane vector RAM reads for CSR non-zero beats and re-aligns
// each returned x[col] with its matrix value in a credit-managed output FIFO.
module vector_gather #(
  parameter int unsigned PARALLELISM = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned LENGTH      = 1024,
  parameter int unsigned ADDR_WIDTH  = $clog2(LENGTH),
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [PARALLELISM*ADDR_WIDTH-1:0] in_col,
  input  logic [PARALLELISM*DATA_WIDTH-1:0] in_val,
  input  logic [PARALLELISM-1:0]            in_mask,
  input  logic                              in_last,
  output logic [PARALLELISM*ADDR_WIDTH-1:0] ram_addr,
  output logic [PARALLELISM-1:0]            ram_valid,
  output logic [PARALLELISM-1:0]            ram_write,
  input  logic [PARALLELISM*DATA_WIDTH-1:0] ram_rdata,
  input  logic [PARALLELISM-1:0]            ram_rvalid,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [PARALLELISM*DATA_WIDTH-1:0] out_val,
  output logic [PARALLELISM*DATA_WIDTH-1:0] out_x,
  output logic [PARALLELISM-1:0]            out_mask,
  output logic                              out_last,
  output logic                              err
);

  localparam int unsigned VEC_W = PARALLELISM * DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef struct packed {
    logic [VEC_W-1:0]       val;
    logic [VEC_W-1:0]       x;
    logic [PARALLELISM-1:0] mask;
    logic                   last;
  } entry_t;

  logic                   hs_c;
  logic                   push_c;
  logic                   pop_c;
  entry_t                 wr_entry_c;

  logic                   ready_q, ready_d;
  logic                   inflight_q, inflight_d;
  logic [VEC_W-1:0]       val_q, val_d;
  logic [PARALLELISM-1:0] mask_q, mask_d;
  logic                   last_q, last_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [PTR_W-1:0]       wptr_q, wptr_d;
  logic [PTR_W-1:0]       rptr_q, rptr_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  entry_t                 mem_q [FIFO_DEPTH];

  // Request path is combinational from the accepted input beat
  assign hs_c      = in_valid && ready_q;
  assign ram_addr  = in_col;
  assign ram_valid = in_mask & {PARALLELISM{hs_c}};
  assign ram_write = '0;

  // Sideband capture so val/mask/last line up with ram_rdata one cycle later
  always_comb begin
    inflight_d = hs_c;
    val_d      = val_q;
    mask_d     = mask_q;
    last_d     = last_q;
    if (hs_c) begin
      val_d  = in_val;
      mask_d = in_mask;
      last_d = in_last;
    end
  end

  // Inactive lanes carry x = 0 regardless of what the RAM returned
  always_comb begin
    wr_entry_c      = '0;
    wr_entry_c.val  = val_q;
    wr_entry_c.mask = mask_q;
    wr_entry_c.last = last_q;
    for (int unsigned j = 0; j < PARALLELISM; j++) begin
      if (mask_q[j]) begin
        wr_entry_c.x[j*DATA_WIDTH +: DATA_WIDTH] = ram_rdata[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign push_c = inflight_q;
  assign pop_c  = valid_q && out_ready;

  // FIFO bookkeeping; credits count both stored entries and the read in flight
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_c) begin
      wptr_d = (wptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rptr_d = (rptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    valid_d = (count_d != '0);
    ready_d = (32'(count_d) + 32'(inflight_d)) < FIFO_DEPTH;
  end

  // Returned valids must match the lanes requested one cycle earlier
  always_comb begin
    err_d = err_q;
    if (inflight_q) begin
      if (ram_rvalid != mask_q) begin
        err_d = 1'b1;
      end
    end else if (ram_rvalid != '0) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q    <= 1'b0;
      inflight_q <= 1'b0;
      val_q      <= '0;
      mask_q     <= '0;
      last_q     <= 1'b0;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ready_q    <= ready_d;
      inflight_q <= inflight_d;
      val_q      <= val_d;
      mask_q     <= mask_d;
      last_q     <= last_d;
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_c) begin
      mem_q[wptr_q] <= wr_entry_c;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_val   = mem_q[rptr_q].val;
  assign out_x     = mem_q[rptr_q].x;
  assign out_mask  = mem_q[rptr_q].mask;
  assign out_last  = mem_q[rptr_q].last;
  assign err       = err_q;

endmodule

// File: tb/tb_vector_gather.sv
// tb_vector_gather: table-driven, directed and randomized checks of vector_gather
// against a queue-based model where x[k] = k + 100.
module tb_vector_gather;

  localparam int unsigned P     = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned LEN   = 1024;
  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned VW    = P * DW;
  localparam int unsigned CW    = P * AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_col;
  logic [VW-1:0] in_val;
  logic [P-1:0]  in_mask;
  logic          in_last;
  logic [CW-1:0] ram_addr;
  logic [P-1:0]  ram_valid;
  logic [P-1:0]  ram_write;
  logic [VW-1:0] ram_rdata;
  logic [P-1:0]  ram_rvalid;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_val;
  logic [VW-1:0] out_x;
  logic [P-1:0]  out_mask;
  logic          out_last;
  logic          err;

  typedef struct packed {
    logic [VW-1:0] val;
    logic [VW-1:0] x;
    logic [P-1:0]  mask;
    logic          last;
  } exp_t;

  typedef struct {
    logic [CW-1:0] col;
    logic [VW-1:0] val;
    logic [P-1:0]  mask;
    logic          last;
    logic [VW-1:0] exp_x;
    logic [P-1:0]  exp_rv;
  } vec_t;

  int   vectors = 0;
  int   miscompares = 0;
  int   n_pop = 0;
  int   n_hs = 0;
  exp_t exp_q [$];

  logic [DW-1:0] x_mem [LEN];
  logic [VW-1:0] rdata_q;
  logic [P-1:0]  rvalid_q;
  logic [P-1:0]  rv_and;

  always #5 clk = ~clk;

  vector_gather #(
    .PARALLELISM(P), .DATA_WIDTH(DW), .LENGTH(LEN), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_col(in_col), .in_val(in_val),
    .in_mask(in_mask), .in_last(in_last),
    .ram_addr(ram_addr), .ram_valid(ram_valid), .ram_write(ram_write),
    .ram_rdata(ram_rdata), .ram_rvalid(ram_rvalid),
    .out_valid(out_valid), .out_ready(out_ready), .out_val(out_val), .out_x(out_x),
    .out_mask(out_mask), .out_last(out_last), .err(err)
  );

  // Vector RAM: 1-cycle read latency; unrequested lanes return junk
  initial begin
    for (int k = 0; k < int'(LEN); k++) x_mem[k] = DW'(k + 100);
  end

  always @(posedge clk) begin
    for (int j = 0; j < int'(P); j++) begin
      rdata_q[j*DW +: DW] <= ram_valid[j] ? x_mem[ram_addr[j*AW +: AW]] : DW'($urandom);
    end
    rvalid_q <= ram_valid;
  end

  assign ram_rdata  = rdata_q;
  assign ram_rvalid = rvalid_q & rv_and;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [CW-1:0] col, input logic [VW-1:0] val,
                                 input logic [P-1:0] mask, input logic last);
    exp_t e;
    e.val  = val;
    e.mask = mask;
    e.last = last;
    e.x    = '0;
    for (int j = 0; j < int'(P); j++) begin
      if (mask[j]) e.x[j*DW +: DW] = DW'(col[j*AW +: AW]) + DW'(100);
    end
    return e;
  endfunction

  function automatic logic [CW-1:0] pk_col(input int unsigned a, b, c, d);
    return {AW'(d), AW'(c), AW'(b), AW'(a)};
  endfunction

  function automatic logic [VW-1:0] pk_dat(input int unsigned a, b, c, d);
    return {DW'(d), DW'(c), DW'(b), DW'(a)};
  endfunction

  // Scoreboard: sampled mid-cycle, ahead of the edge that performs the transfer
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          chk("pop_without_beat", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("out_entry", {out_val, out_x, out_mask, out_last}, e);
        end
      end
      if (in_valid && in_ready) begin
        n_hs++;
        exp_q.push_back(model(in_col, in_val, in_mask, in_last));
      end
      chk("credit_bound", exp_q.size() > int'(DEPTH), 1'b0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_beat();
    for (int j = 0; j < int'(P); j++) begin
      in_col[j*AW +: AW] = AW'($urandom_range(0, LEN - 1));
      in_val[j*DW +: DW] = DW'($urandom);
    end
    in_mask = P'($urandom);
    in_last = 1'($urandom);
  endtask

  initial begin
    vec_t tbl [5];
    int   p0;
    int   h0;

    tbl[0] = '{pk_col(3, 7, 0, 9), pk_dat(1, 2, 3, 4), 4'b1111, 1'b1,
               pk_dat(103, 107, 100, 109), 4'b1111};
    tbl[1] = '{pk_col(5, 5, 5, 5), pk_dat(10, 11, 12, 13), 4'b0101, 1'b0,
               pk_dat(105, 0, 105, 0), 4'b0101};
    tbl[2] = '{pk_col(0, 0, 0, 0), pk_dat(20, 21, 22, 23), 4'b0000, 1'b1,
               pk_dat(0, 0, 0, 0), 4'b0000};
    tbl[3] = '{pk_col(1023, 1022, 512, 1), pk_dat(7, 8, 9, 10), 4'b1111, 1'b0,
               pk_dat(1123, 1122, 612, 101), 4'b1111};
    tbl[4] = '{pk_col(8, 9, 10, 11), pk_dat(30, 31, 32, 33), 4'b1000, 1'b1,
               pk_dat(0, 0, 0, 111), 4'b1000};

    in_valid  = 1'b0;
    in_col    = '0;
    in_val    = '0;
    in_mask   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    rv_and    = '1;

    #1;
    chk("reset_in_ready", in_ready, 1'b0);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_err", err, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    cyc();
    chk("ready_after_reset", in_ready, 1'b1);

    // Single-beat vectors: request lanes, 2-cycle latency, aligned payload
    for (int i = 0; i < 5; i++) begin
      in_col   = tbl[i].col;
      in_val   = tbl[i].val;
      in_mask  = tbl[i].mask;
      in_last  = tbl[i].last;
      in_valid = 1'b1;
      #1;
      chk("tbl_ram_valid", ram_valid, tbl[i].exp_rv);
      chk("tbl_ram_addr", ram_addr, tbl[i].col);
      chk("tbl_ram_write", ram_write, 4'b0000);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("tbl_out_valid_t1", out_valid, 1'b0);
      cyc();
      chk("tbl_out_valid_t2", out_valid, 1'b1);
      chk("tbl_out_fields", {out_val, out_x, out_mask, out_last},
          {tbl[i].val, tbl[i].exp_x, tbl[i].mask, tbl[i].last});
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      chk("tbl_out_valid_after_pop", out_valid, 1'b0);
    end

    // 16 back-to-back beats with an always-ready sink
    out_ready = 1'b1;
    p0 = n_pop;
    h0 = n_hs;
    for (int i = 0; i < 16; i++) begin
      rand_beat();
      in_valid = 1'b1;
      chk("stream_in_ready", in_ready, 1'b1);
      if (i >= 2) chk("stream_out_valid", out_valid, 1'b1);
      cyc();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("stream_tail_valid", out_valid, 1'b1);
      cyc();
    end
    chk("stream_empty", out_valid, 1'b0);
    chk("stream_pops", n_pop - p0, 16);
    chk("stream_handshakes", n_hs - h0, 16);

    // Backpressure: credits run out after exactly FIFO_DEPTH beats
    out_ready = 1'b0;
    h0 = n_hs;
    for (int i = 0; i < 8; i++) begin
      rand_beat();
      in_valid = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    chk("bp_accepted", n_hs - h0, int'(DEPTH));
    chk("bp_in_ready_low", in_ready, 1'b0);
    chk("bp_out_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    cyc();
    chk("bp_ready_after_pop", in_ready, 1'b1);
    for (int k = 0; k < 20 && out_valid; k++) cyc();
    chk("bp_drained", out_valid, 1'b0);
    chk("bp_queue_empty", exp_q.size(), 0);
    out_ready = 1'b0;

    // Reset with 3 entries buffered and one read in flight
    for (int i = 0; i < 4; i++) begin
      rand_beat();
      in_valid = 1'b1;
      chk("rst_fill_ready", in_ready, 1'b1);
      cyc();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_err", err, 1'b0);
    cyc();
    chk("rst_hold_in_ready", in_ready, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    cyc();
    chk("rst_release_ready", in_ready, 1'b1);
    chk("rst_release_valid", out_valid, 1'b0);
    chk("rst_release_err", err, 1'b0);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("rst_no_stale_out", out_valid, 1'b0);
      chk("rst_no_err", err, 1'b0);
    end

    // Randomized traffic and backpressure against the scoreboard
    for (int i = 0; i < 400; i++) begin
      rand_beat();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      cyc();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && (out_valid || exp_q.size() != 0); k++) cyc();
    chk("rand_queue_empty", exp_q.size(), 0);
    chk("rand_out_idle", out_valid, 1'b0);
    chk("rand_no_err", err, 1'b0);

    // Corrupted rvalid on a full-mask return sets a sticky error
    in_col   = pk_col(1, 2, 3, 4);
    in_val   = pk_dat(5, 6, 7, 8);
    in_mask  = 4'b1111;
    in_last  = 1'b0;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    rv_and   = 4'b1110;
    chk("err_before_return", err, 1'b0);
    cyc();
    rv_and = '1;
    chk("err_set", err, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("err_sticky", err, 1'b1);
    end
    rst_n = 1'b0;
    #1;
    chk("err_cleared", err, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vector_gather.md
Name: vector_gather

Overview:
- Upstream stage of the SpMV multiply lane.
- Accepts beats of CSR non-zeros, each carrying PARALLELISM (column index, matrix value) lanes.
- Issues one read per active lane to the read-only port of the vector RAM. The RAM port has fixed 1-cycle latency and is always ready.
- Re-aligns each returned x[col] with its matrix value and buffers the pairs in an output FIFO, so the downstream multiplier can apply backpressure without stalling the RAM pipeline.

Parameters:
- PARALLELISM, 4: lanes per beat; equals the vector RAM's PARALLELISM.
- DATA_WIDTH, 32: width of matrix values and vector elements.
- LENGTH, 1024: vector RAM depth in elements.
- ADDR_WIDTH, $clog2(LENGTH): column index width.
- FIFO_DEPTH, 4: output FIFO entries. Must be ≥2; ≥3 is required for full throughput.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_col  in  PARALLELISM*ADDR_WIDTH  column index per lane; lane i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- in_val  in  PARALLELISM*DATA_WIDTH  matrix value per lane.
- in_mask  in  PARALLELISM  lane active.
- in_last  in  1  last beat of a row.
- ram_addr  out  PARALLELISM*ADDR_WIDTH  read address per lane.
- ram_valid  out  PARALLELISM  per-lane read request.
- ram_write  out  PARALLELISM  tied 0.
- ram_rdata  in  PARALLELISM*DATA_WIDTH  read data, valid 1 cycle after request.
- ram_rvalid  in  PARALLELISM  per-lane read-data valid.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accepts head.
- out_val  out  PARALLELISM*DATA_WIDTH  matrix values.
- out_x  out  PARALLELISM*DATA_WIDTH  gathered vector elements; masked lanes are 0.
- out_mask  out  PARALLELISM  lane mask.
- out_last  out  1  row-end flag.
- err  out  1  sticky protocol error.

Behaviour:
- Reset values: in_ready=0, out_valid=0, err=0, FIFO count=0, inflight=0, all sideband registers 0.
- Clock is clk; reset is rst_n, asynchronous assert, active-low, synchronous release via the flop reset path.
- Request path is combinational from the input: ram_addr=in_col, ram_valid=in_mask & {PARALLELISM{in_valid && in_ready}}, ram_write=0.
- Credits: in_ready = (count + inflight) < FIFO_DEPTH.
  - in_ready is registered-state only and never depends on out_ready.
  - inflight is 1 flop, set on an input handshake in cycle t and cleared in t+1 unless a new handshake occurs.
- Sideband pipeline: in_val, in_mask, in_last are registered on handshake to align with ram_rdata one cycle later.
- Push: in cycle t+1 with inflight=1, write {val_q, rdata & lane mask, mask_q, last_q} into the FIFO at the end of t+1.
  - Lane j of x is ram_rdata lane j when mask_q[j], else 0.
- Latency: handshake at edge t → out_valid high in cycle t+2 (FIFO head registered/memory-read), provided the FIFO was empty.
- Throughput: one beat per cycle sustained when FIFO_DEPTH≥3 and out_ready=1.
- FIFO:
  - Circular buffer with read/write pointers wrapping modulo FIFO_DEPTH.
  - count updates by +push −pop; a simultaneous push and pop leaves count unchanged.
  - Pop on out_valid && out_ready.
  - out_valid = count≠0.
  - Overflow is impossible by the credit rule.
- Error: set err (sticky until reset) when inflight=1 and ram_rvalid≠mask_q, or when ram_rvalid≠0 while inflight=0. Data is still pushed normally.
- A beat with in_mask=0 is accepted and produces an entry with out_mask=0, out_x=0, carrying in_last. This is used for empty rows.
- Reset mid-operation:
  - FIFO and inflight are flushed.
  - A RAM return arriving after release is ignored because inflight=0 (err is not set, since ram_valid was low at the time of reset).
  - No output is produced for beats accepted before reset.

Test Plan:
- Single beat, vector RAM preloaded x[k]=k+100; col={3,7,0,9}, val={1,2,3,4}, mask=4'b1111, last=1 → exactly 2 cycles after the handshake, out_valid=1, out_x={103,107,100,109}, out_val={1,2,3,4}, out_last=1.
- Stream 16 beats back-to-back with out_ready=1 and FIFO_DEPTH=4 → in_ready stays 1, 16 outputs on consecutive cycles in order, inflight+count never exceeds 4.
- out_ready=0 while streaming → exactly 4 beats accepted, then in_ready=0. Raise out_ready → outputs drain in order, and in_ready returns 1 the cycle after the first pop.
- mask=4'b0101, col={5,5,5,5} → ram_valid=4'b0101, out_x lanes 1 and 3 are 0, lanes 0 and 2 equal x[5]. Also mask=0 with last=1 → one entry with out_mask=0, out_last=1.
- Assert rst_n low for 1 cycle while 3 entries are buffered and one read is in flight → out_valid=0 and in_ready=0 during reset, in_ready=1 on the first cycle after release, no stale outputs, err=0.
- Force ram_rvalid=4'b1110 on the return of a full-mask beat → err=1 from the next cycle and it stays 1 until reset.
